btb_gshare_predictor: RTL and testbench

- Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) plus a gshare global predictor (global history register + table of 2-bit counters).
- Minimal MIPS branch/jump decode of two instructions: the fetched instruction, and the resolved instruction returning from MEM.
- Prediction for the fetched PC is combinational, in the same cycle.
- Tables and history update on the rising clock edge from the MEM-stage resolution.

---
 rtl/btb_gshare_predictor.sv | 120 ++++++++++++
 tb/tb_btb_gshare_predictor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/btb_gshare_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus gshare direction table.
// Prediction is combinational on the fetched PC; tables update from the MEM-stage resolution.
module btb_gshare_predictor #(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FLUSH,
    input  logic [31:0] Instr_input,
    input  logic [31:0] Instr_addr_input,
    input  logic [31:0] Branch_instr,
    input  logic [31:0] Branch_addr,
    input  logic        Branch_resolved,
    input  logic [31:0] Branch_resolved_addr,
    output logic        Taken,
    output logic [31:0] Taken_addr
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;
    localparam int PHT_N   = 1 << GHR_BITS;

    function automatic logic is_cond(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == 6'd1) || (op == 6'd4) || (op == 6'd5) || (op == 6'd6) || (op == 6'd7);
    endfunction

    function automatic logic is_jump(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] funct;
        op    = instr[31:26];
        funct = instr[5:0];
        return (op == 6'd2) || (op == 6'd3) ||
               ((op == 6'd0) && ((funct == 6'd8) || (funct == 6'd9)));
    endfunction

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        end
        return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    endfunction

    logic [ENTRIES-1:0]  btb_valid;
    logic [TAG_W-1:0]    btb_tag    [ENTRIES];
    logic [31:0]         btb_target [ENTRIES];
    logic [1:0]          pht        [PHT_N];
    logic [GHR_BITS-1:0] ghr;

    logic [IDX_BITS-1:0] fetch_idx;
    logic [TAG_W-1:0]    fetch_tag;
    logic [GHR_BITS-1:0] fetch_pht_idx;
    logic                hit;
    logic                pred;

    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic [GHR_BITS-1:0] upd_pht_idx;
    logic                upd_cond;
    logic                btb_wr;
    logic                unused_bits;

    assign fetch_idx     = Instr_addr_input[IDX_BITS+1:2];
    assign fetch_tag     = Instr_addr_input[31:IDX_BITS+2];
    assign fetch_pht_idx = Instr_addr_input[GHR_BITS+1:2] ^ ghr;

    assign upd_idx     = Branch_addr[IDX_BITS+1:2];
    assign upd_tag     = Branch_addr[31:IDX_BITS+2];
    assign upd_pht_idx = Branch_addr[GHR_BITS+1:2] ^ ghr;
    assign upd_cond    = is_cond(Branch_instr);
    assign btb_wr      = (upd_cond || is_jump(Branch_instr)) && Branch_resolved;

    // Only opcode/funct and word-aligned address bits participate in the decode.
    assign unused_bits = ^{Instr_input[25:6], Branch_instr[25:6],
                           Instr_addr_input[1:0], Branch_addr[1:0]};

    always_comb begin
        pred = 1'b0;
        hit  = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
        if (is_jump(Instr_input)) begin
            pred = 1'b1;
        end else if (is_cond(Instr_input)) begin
            pred = pht[fetch_pht_idx][1];
        end
        Taken      = pred && hit && !FLUSH;
        Taken_addr = Taken ? btb_target[fetch_idx] : 32'd0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            btb_valid <= '0;
        end else if (btb_wr) begin
            btb_valid[upd_idx] <= 1'b1;
        end
    end

    // Tag and target are qualified by the valid bit, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (btb_wr && RESET) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= Branch_resolved_addr;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= 2'b01;
            end
            ghr <= '0;
        end else if (upd_cond) begin
            pht[upd_pht_idx] <= ctr_next(pht[upd_pht_idx], Branch_resolved);
            ghr              <= {ghr[GHR_BITS-2:0], Branch_resolved};
        end
    end

endmodule

// File: tb/tb_btb_gshare_predictor.sv
// Directed bench for btb_gshare_predictor: reset, gshare training, jumps, aliasing, flush, async reset.
module tb_btb_gshare_predictor;

    localparam logic [31:0] BEQ    = 32'h10220003;
    localparam logic [31:0] JMP    = 32'h08100040;
    localparam logic [31:0] A_BEQ  = 32'h00400010;
    localparam logic [31:0] T_BEQ  = 32'h00400020;
    localparam logic [31:0] A_JMP  = 32'h00400000;
    localparam logic [31:0] A_JMP2 = 32'h00400100;
    localparam logic [31:0] A_JMP3 = 32'h00400200;

    logic        CLK;
    logic        RESET;
    logic        FLUSH;
    logic [31:0] Instr_input;
    logic [31:0] Instr_addr_input;
    logic [31:0] Branch_instr;
    logic [31:0] Branch_addr;
    logic        Branch_resolved;
    logic [31:0] Branch_resolved_addr;
    logic        Taken;
    logic [31:0] Taken_addr;

    int n_cmp = 0;
    int n_err = 0;

    btb_gshare_predictor #(.IDX_BITS(6), .GHR_BITS(8)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .FLUSH               (FLUSH),
        .Instr_input         (Instr_input),
        .Instr_addr_input    (Instr_addr_input),
        .Branch_instr        (Branch_instr),
        .Branch_addr         (Branch_addr),
        .Branch_resolved     (Branch_resolved),
        .Branch_resolved_addr(Branch_resolved_addr),
        .Taken               (Taken),
        .Taken_addr          (Taken_addr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_pred(input string tag, input logic t, input logic [31:0] a);
        check({tag, "_taken"}, {31'd0, Taken}, {31'd0, t});
        check({tag, "_addr"}, Taken_addr, a);
    endtask

    task automatic set_fetch(input logic [31:0] instr, input logic [31:0] addr);
        Instr_input      = instr;
        Instr_addr_input = addr;
    endtask

    task automatic set_upd(input logic [31:0] instr, input logic [31:0] addr,
                           input logic res, input logic [31:0] raddr);
        Branch_instr         = instr;
        Branch_addr          = addr;
        Branch_resolved      = res;
        Branch_resolved_addr = raddr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        FLUSH = 1'b0;
        set_fetch(BEQ, A_BEQ);
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        #2;
        expect_pred("in_reset", 1'b0, 32'd0);
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b1;
        tick();

        // Cold fetch of the beq: BTB empty
        set_fetch(BEQ, A_BEQ);
        #1 expect_pred("cold_beq", 1'b0, 32'd0);

        // Jump resolved once, then fetched
        set_upd(JMP, A_JMP, 1'b1, 32'h00400100);
        tick();
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        set_fetch(JMP, A_JMP);
        #1 expect_pred("jump", 1'b1, 32'h00400100);

        // Gshare training; GHR still 0 so the index walk follows the hand-computed sequence
        set_fetch(BEQ, A_BEQ);
        set_upd(BEQ, A_BEQ, 1'b1, T_BEQ);
        repeat (8) tick();
        expect_pred("train_n8", 1'b0, 32'd0);
        tick();
        expect_pred("train_n9", 1'b1, T_BEQ);
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        #1 expect_pred("train_hold", 1'b1, T_BEQ);

        // Aliasing and non-branch fetches
        set_fetch(BEQ, 32'h00400110);
        #1 expect_pred("alias_tag", 1'b0, 32'd0);
        set_fetch(32'd0, A_BEQ);
        #1 expect_pred("non_branch", 1'b0, 32'd0);
        set_fetch(JMP, A_JMP);
        #1 expect_pred("jump_again", 1'b1, 32'h00400100);

        // Alias overwrite of entry 0 by another jump
        set_upd(JMP, A_JMP2, 1'b1, 32'h00400200);
        tick();
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        set_fetch(JMP, A_JMP);
        #1 expect_pred("alias_evicted", 1'b0, 32'd0);
        set_fetch(JMP, A_JMP2);
        #1 expect_pred("alias_new", 1'b1, 32'h00400200);

        // Not-taken resolution neither invalidates nor rewrites the target
        set_upd(JMP, A_JMP2, 1'b0, 32'h12345678);
        tick();
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        #1 expect_pred("nt_no_inval", 1'b1, 32'h00400200);

        // Not-taken training of the beq; pre-edge read still sees old state
        set_fetch(BEQ, A_BEQ);
        set_upd(BEQ, A_BEQ, 1'b0, 32'hDEADBEEC);
        #1 expect_pred("same_cycle", 1'b1, T_BEQ);
        repeat (3) tick();
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        #1 expect_pred("nt_trained", 1'b0, 32'd0);

        // Retrain taken: GHR F8 -> F1,E3,C7,8F,1F; index 1B was trained earlier
        set_upd(BEQ, A_BEQ, 1'b1, T_BEQ);
        repeat (4) tick();
        expect_pred("retrain_4", 1'b0, 32'd0);
        tick();
        expect_pred("retrain_5", 1'b1, T_BEQ);

        // Flush masks the prediction but the update still lands
        FLUSH = 1'b1;
        set_upd(JMP, A_JMP3, 1'b1, 32'h00400300);
        #1 expect_pred("flush", 1'b0, 32'd0);
        tick();
        FLUSH = 1'b0;
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        set_fetch(JMP, A_JMP3);
        #1 expect_pred("flush_upd", 1'b1, 32'h00400300);
        set_fetch(JMP, A_JMP2);
        #1 expect_pred("flush_evict", 1'b0, 32'd0);

        // Asynchronous reset mid-cycle, with updates presented while held
        set_fetch(BEQ, A_BEQ);
        #1 expect_pred("pre_reset", 1'b1, T_BEQ);
        set_upd(BEQ, A_BEQ, 1'b1, T_BEQ);
        #2 RESET = 1'b0;
        #1 expect_pred("async_reset", 1'b0, 32'd0);
        repeat (2) tick();
        expect_pred("held_reset", 1'b0, 32'd0);
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        RESET = 1'b1;
        #1 expect_pred("post_reset_beq", 1'b0, 32'd0);
        set_fetch(JMP, A_JMP3);
        #1 expect_pred("post_reset_jmp", 1'b0, 32'd0);

        // One taken edge after reset: GHR 0->1, fetch reads PHT[05] which must be back at 01
        set_fetch(BEQ, A_BEQ);
        set_upd(BEQ, A_BEQ, 1'b1, T_BEQ);
        tick();
        set_upd(32'd0, 32'd0, 1'b0, 32'd0);
        #1 expect_pred("pht_reset", 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
